sp_ram_bytewr: RTL
==================

Name: sp_ram_bytewr

Overview:
- Next-generation single-port synchronous RAM. Generalises the fixed read-first / write-first / no-change variants into one parametrised block.
- Read-during-write mode is selected by parameter.
- Adds per-byte write enables, a read-valid strobe, and a hardware clear sequencer. The sequencer zero-fills the whole array after reset or on request.
- Sits between register-file/buffer logic and any client needing a cleared, byte-addressable scratch memory.

Parameters:
- MEM_WIDTH, 24, data word width in bits; must be an integer multiple of BYTE_WIDTH.
- ADDR_WIDTH, 8, address width; depth = 2**ADDR_WIDTH words.
- BYTE_WIDTH, 8, bits per write-enable lane; NB = MEM_WIDTH/BYTE_WIDTH lanes (default 3).
- RD_MODE, 0, read-during-write behaviour: 0 read-first, 1 write-first, 2 no-change.
- CLEAR_VAL, 0, MEM_WIDTH-bit value written to every word by the clear sequencer.

Ports:
- clk  in  1  rising-edge clock for all logic.
- rst  in  1  synchronous, active-high reset.
- en  in  1  access request: read, or write if we=1.
- we  in  1  write enable, qualified by en.
- be  in  NB  byte-lane write enables; lane i covers din[i*BYTE_WIDTH +: BYTE_WIDTH].
- addr  in  ADDR_WIDTH  word address.
- din  in  MEM_WIDTH  write data.
- clr_req  in  1  single-cycle request to re-run the clear sequence.
- dout  out  MEM_WIDTH  read data.
- dout_valid  out  1  one-cycle strobe marking new data on dout.
- busy  out  1  clear sequence in progress; client accesses are ignored.

Behaviour:
- Reset: rst sampled high sets state=CLEAR, clr_addr=0, busy=1, dout=0, dout_valid=0. Memory array contents are not reset directly.
- Reset mid-clear or mid-access restarts the clear at address 0.
- FSM states: CLEAR and RUN.
- CLEAR behaviour:
  - Each cycle writes CLEAR_VAL to mem[clr_addr], all lanes, then increments clr_addr.
  - On the cycle clr_addr = 2**ADDR_WIDTH-1 is written, next state = RUN and busy <= 0.
  - busy is therefore high for exactly 2**ADDR_WIDTH edges after rst deasserts (256 by default).
  - The counter wrap is never used to re-enter CLEAR.
- During CLEAR:
  - en, we, be, addr, din and clr_req are ignored.
  - dout holds its value; dout_valid = 0.
- RUN, accepted access (en=1):
  - Write (we=1): mem[addr] lanes with be[i]=1 take din lanes; lanes with be[i]=0 keep their old value.
  - be=0 with we=1 changes no memory, but is still treated as a write for dout purposes.
- Read latency 1: dout and dout_valid update on the edge that samples en=1.
  - dout_valid = 1 for one cycle after every accepted access with we=0.
  - dout_valid also = 1 after accepted writes in RD_MODE 0 and 1.
  - dout_valid = 0 after writes in RD_MODE 2.
- dout on a write cycle:
  - RD_MODE 0: old stored word at addr.
  - RD_MODE 1: merged word, i.e. new lanes where be=1 and old lanes elsewhere.
  - RD_MODE 2: dout unchanged.
- en=0: dout holds, dout_valid = 0.
- clr_req=1 in RUN: the access on that same cycle is ignored. Next state = CLEAR, clr_addr = 0, busy = 1 from the next edge.
- Illegal RD_MODE values (>2) behave as 0.
- MEM_WIDTH not divisible by BYTE_WIDTH is a parameter error, flagged with an elaboration-time $error.

Optional Feature:
- Macro: SP_RAM_OUT_REG_EN.
- Defined:
  - Adds one output pipeline register after the array read: dout and dout_valid are delayed one further cycle, giving read latency 2.
  - The pipeline register resets to 0 with rst.
  - It keeps advancing during CLEAR so in-flight data drains; no new valid is launched.
- Undefined: latency 1 as above, no extra register.

Test Plan:
- Reset then idle:
  - rst high 2 cycles, release -> busy=1 for 256 cycles then 0.
  - Read addr 0x00, 0x7F and 0xFF -> dout=0x000000, dout_valid=1 one cycle after each.
- Full-word write/read, RD_MODE=0:
  - Write 0xAAAAAA to 0x05 with be=3'b111 -> write-cycle dout=0x000000 (old).
  - Read 0x05 -> 0xAAAAAA.
  - Write 0x111111 -> write-cycle dout=0xAAAAAA.
  - Read 0x05 -> 0x111111.
- Byte lanes, RD_MODE=1:
  - 0x05 holds 0xAAAAAA; write din=0x123456 with be=3'b010 -> write-cycle dout=0xAA34AA, stored 0xAA34AA.
  - be=3'b000 write -> memory unchanged, dout=0xAA34AA.
- No-change mode, RD_MODE=2:
  - Read 0x05 gives 0xAAAAAA; then write 0x555555 -> dout stays 0xAAAAAA, dout_valid=0.
  - Read 0x05 -> 0x555555.
- clr_req and mid-clear reset:
  - After writing 0xAAAAAA to 0x05, pulse clr_req -> busy=1 for 256 cycles; accesses during busy ignored; read 0x05 after -> 0x000000.
  - Assert rst at clear cycle 100 -> busy stays high for a fresh 256 cycles after release.
- SP_RAM_OUT_REG_EN defined:
  - Read 0x05 holding 0x111111 -> dout=0x111111 and dout_valid=1 two edges after en, not one.
  - Back-to-back reads of 0x05 and 0x06 produce results on consecutive cycles.

Source files
------------

// File: rtl/sp_ram_bytewr.sv
// Single-port synchronous RAM with per-byte write enables, a selectable read-during-write mode,
// and a zero-fill clear sequencer. Define SP_RAM_OUT_REG_EN to add an output pipeline register.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_CLEAR | sequencer writes CLEAR_VAL to mem[clr_addr]; client ignored
// S_RUN   | client reads/writes accepted
module sp_ram_bytewr #(
  parameter int MEM_WIDTH  = 24,
  parameter int ADDR_WIDTH = 8,
  parameter int BYTE_WIDTH = 8,
  parameter int RD_MODE    = 0,
  parameter logic [MEM_WIDTH-1:0] CLEAR_VAL = '0,
  localparam int NB = MEM_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  we,
  input  logic [NB-1:0]         be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [MEM_WIDTH-1:0]  din,
  input  logic                  clr_req,
  output logic [MEM_WIDTH-1:0]  dout,
  output logic                  dout_valid,
  output logic                  busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // Out-of-range modes fall back to read-first.
  localparam int MODE = (RD_MODE == 1 || RD_MODE == 2) ? RD_MODE : 0;

  if (MEM_WIDTH % BYTE_WIDTH != 0) begin : g_width_check
    $error("sp_ram_bytewr: MEM_WIDTH (%0d) must be a multiple of BYTE_WIDTH (%0d)",
           MEM_WIDTH, BYTE_WIDTH);
  end

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   clr_addr, clr_addr_n;
  logic [MEM_WIDTH-1:0]    mem [DEPTH];
  logic [MEM_WIDTH-1:0]    old_word;
  logic [MEM_WIDTH-1:0]    merged;
  logic                    acc;
  logic                    acc_wr;
  logic                    clr_last;
  logic [MEM_WIDTH-1:0]    rd_data;
  logic                    rd_valid;

  assign busy     = (state == S_CLEAR);
  assign clr_last = (clr_addr == {ADDR_WIDTH{1'b1}});
  assign acc      = (state == S_RUN) && en && !clr_req;
  assign acc_wr   = acc && we;
  assign old_word = mem[addr];

  always_comb begin
    merged = old_word;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) merged[i*BYTE_WIDTH +: BYTE_WIDTH] = din[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_n;
      clr_addr <= clr_addr_n;
    end
  end

  always_comb begin
    state_n    = state;
    clr_addr_n = clr_addr;
    case (state)
      S_CLEAR: begin
        clr_addr_n = clr_addr + ADDR_WIDTH'(1);
        if (clr_last) state_n = S_RUN;
      end
      S_RUN: begin
        if (clr_req) begin
          state_n    = S_CLEAR;
          clr_addr_n = '0;
        end
      end
      default: begin
        state_n    = S_CLEAR;
        clr_addr_n = '0;
      end
    endcase
  end

  // Array itself is never reset; the sequencer zero-fills it instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_CLEAR) mem[clr_addr] <= CLEAR_VAL;
      else if (acc_wr)      mem[addr]     <= merged;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (acc) begin
        if (!we) begin
          rd_data  <= old_word;
          rd_valid <= 1'b1;
        end else if (MODE == 1) begin
          rd_data  <= merged;
          rd_valid <= 1'b1;
        end else if (MODE == 0) begin
          rd_data  <= old_word;
          rd_valid <= 1'b1;
        end
      end
    end
  end

`ifdef SP_RAM_OUT_REG_EN
  logic [MEM_WIDTH-1:0] out_data;
  logic                 out_valid;

  // Keeps shifting during clear so any in-flight result still drains out.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_data  <= rd_data;
      out_valid <= rd_valid;
    end
  end

  assign dout       = out_data;
  assign dout_valid = out_valid;
`else
  assign dout       = rd_data;
  assign dout_valid = rd_valid;
`endif

endmodule
